// File: rtl/sram_port_arbiter_if.sv
// Core-side inst/data SRAM ports, unified memory port and status
// flags shared between the arbiter and its environment.
interface sram_port_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_ok;
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_ok;
  logic        mem_req;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stallreq;
  logic        timeout_err;

  modport slave (
    input  inst_req, inst_addr,
    input  data_req, data_wen, data_addr, data_wdata,
    input  mem_rdata, mem_ready,
    output inst_rdata, inst_ok,
    output data_rdata, data_ok,
    output mem_req, mem_wen, mem_addr, mem_wdata,
    output stallreq, timeout_err
  );

  modport master (
    output inst_req, inst_addr,
    output data_req, data_wen, data_addr, data_wdata,
    output mem_rdata, mem_ready,
    input  inst_rdata, inst_ok,
    input  data_rdata, data_ok,
    input  mem_req, mem_wen, mem_addr, mem_wdata,
    input  stallreq, timeout_err
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between fetch and data requesters:
// data-first priority, bounded data streak, per-access timeout.
module sram_port_arbiter #(
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT         = 255
) (
  input  logic                clk,
  input  logic                rst,
  sram_port_arbiter_if.slave  bus
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);
  localparam logic [7:0]    TO_LIM     = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    INST_BUSY,
    DATA_BUSY
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [7:0]    wait_q, wait_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    wen_q, wen_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          err_q, err_d;
  logic          done;
  logic          to_hit;
  logic          data_first;

  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    wait_d     = wait_q;
    addr_d     = addr_q;
    wen_d      = wen_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    done       = 1'b0;
    to_hit     = (wait_q == TO_LIM);
    data_first = bus.data_req &&
                 !(bus.inst_req && streak_q == STREAK_MAX);
    unique case (state_q)
      IDLE: begin
        if (data_first) begin
          state_d = DATA_BUSY;
          addr_d  = bus.data_addr;
          wen_d   = bus.data_wen;
          wdata_d = bus.data_wdata;
          wait_d  = 8'd1;
          if (!bus.inst_req)
            streak_d = '0;
          else if (streak_q != STREAK_MAX)
            streak_d = streak_q + SW'(1);
        end else if (bus.inst_req) begin
          state_d  = INST_BUSY;
          addr_d   = bus.inst_addr;
          wen_d    = 4'd0;
          wdata_d  = 32'd0;
          wait_d   = 8'd1;
          streak_d = '0;
        end
      end
      INST_BUSY, DATA_BUSY: begin
        wait_d = wait_q + 8'd1;
        if (bus.mem_ready || to_hit) begin
          done    = 1'b1;
          state_d = IDLE;
          // a ready in the limit cycle still counts as a completion
          if (!bus.mem_ready)
            err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      streak_q <= '0;
      wait_q   <= 8'd0;
      addr_q   <= 32'd0;
      wen_q    <= 4'd0;
      wdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      wait_q   <= wait_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
    end
  end

  // an access abandoned by reset never reports completion
  assign bus.inst_ok = done && !rst && state_q == INST_BUSY;
  assign bus.data_ok = done && !rst && state_q == DATA_BUSY;

  assign bus.inst_rdata = bus.mem_ready ? bus.mem_rdata : 32'd0;
  assign bus.data_rdata = (bus.mem_ready && wen_q == 4'd0)
                        ? bus.mem_rdata : 32'd0;

  assign bus.mem_req     = (state_q != IDLE);
  assign bus.mem_wen     = wen_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.timeout_err = err_q;

  assign bus.stallreq = (bus.inst_req && !bus.inst_ok) ||
                        (bus.data_req && !bus.data_ok);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: reset, fetch, store,
// priority, streak limit and timeout paths.
module tb_sram_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  sram_port_arbiter_if bus();

  sram_port_arbiter #(
    .MAX_DATA_STREAK(4),
    .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    bus.inst_req   = 1'b0;
    bus.inst_addr  = 32'd0;
    bus.data_req   = 1'b0;
    bus.data_wen   = 4'd0;
    bus.data_addr  = 32'd0;
    bus.data_wdata = 32'd0;
    bus.mem_rdata  = 32'd0;
    bus.mem_ready  = 1'b0;
  end

  initial begin
    logic saw_ok;
    logic exp_inst;

    // power-on reset
    @(negedge clk);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wen", 32'(bus.mem_wen), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_err", 32'(bus.timeout_err), 32'd0);

    // reset while DATA_BUSY abandons the access
    bus.data_req  = 1'b1;
    bus.data_addr = 32'h8000_0100;
    tick();
    #1;
    chk("mid_busy", 32'(bus.mem_req), 32'd1);
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    saw_ok = bus.data_ok;
    bus.mem_ready = 1'b0;
    bus.data_req  = 1'b0;
    tick();
    #1;
    saw_ok = saw_ok | bus.data_ok;
    chk("mid_rst_req", 32'(bus.mem_req), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    saw_ok = saw_ok | bus.data_ok;
    chk("mid_rst_ok", 32'(saw_ok), 32'd0);
    chk("mid_rst_req2", 32'(bus.mem_req), 32'd0);
    chk("mid_rst_err", 32'(bus.timeout_err), 32'd0);

    // single fetch, ready in 3rd busy cycle
    tick();
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'hBFC0_0000;
    #1;
    chk("f_stall0", 32'(bus.stallreq), 32'd1);
    tick();
    #1;
    chk("f_req", 32'(bus.mem_req), 32'd1);
    chk("f_addr", bus.mem_addr, 32'hBFC0_0000);
    chk("f_wen", 32'(bus.mem_wen), 32'd0);
    chk("f_ok1", 32'(bus.inst_ok), 32'd0);
    chk("f_stall1", 32'(bus.stallreq), 32'd1);
    tick();
    #1;
    chk("f_ok2", 32'(bus.inst_ok), 32'd0);
    tick();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h2408_0001;
    #1;
    chk("f_ok3", 32'(bus.inst_ok), 32'd1);
    chk("f_rdata", bus.inst_rdata, 32'h2408_0001);
    chk("f_stall3", 32'(bus.stallreq), 32'd0);
    tick();
    bus.mem_ready = 1'b0;
    bus.inst_req  = 1'b0;
    #1;
    chk("f_ok4", 32'(bus.inst_ok), 32'd0);
    chk("f_idle", 32'(bus.mem_req), 32'd0);

    // mem_ready while idle is ignored
    bus.mem_ready = 1'b1;
    #1;
    chk("idle_rdy_i", 32'(bus.inst_ok), 32'd0);
    chk("idle_rdy_d", 32'(bus.data_ok), 32'd0);
    tick();
    bus.mem_ready = 1'b0;
    #1;
    chk("idle_rdy_req", 32'(bus.mem_req), 32'd0);

    // zero-wait store
    bus.data_req   = 1'b1;
    bus.data_wen   = 4'b0011;
    bus.data_addr  = 32'h8000_0010;
    bus.data_wdata = 32'hDEAD_BEEF;
    tick();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    #1;
    chk("st_wen", 32'(bus.mem_wen), 32'h3);
    chk("st_addr", bus.mem_addr, 32'h8000_0010);
    chk("st_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    chk("st_ok", 32'(bus.data_ok), 32'd1);
    chk("st_rdata", bus.data_rdata, 32'd0);
    tick();
    bus.mem_ready = 1'b0;
    bus.data_req  = 1'b0;
    bus.data_wen  = 4'd0;

    // simultaneous requests: data first, then inst
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h0000_1000;
    bus.data_req  = 1'b1;
    bus.data_addr = 32'h0000_2000;
    tick();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hAAAA_0001;
    #1;
    chk("sim_d_addr", bus.mem_addr, 32'h0000_2000);
    chk("sim_d_ok", 32'(bus.data_ok), 32'd1);
    chk("sim_d_iok", 32'(bus.inst_ok), 32'd0);
    chk("sim_d_rdata", bus.data_rdata, 32'hAAAA_0001);
    tick();
    bus.mem_ready = 1'b0;
    bus.data_req  = 1'b0;
    #1;
    chk("sim_gap", 32'(bus.mem_req), 32'd0);
    tick();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hBBBB_0002;
    #1;
    chk("sim_i_addr", bus.mem_addr, 32'h0000_1000);
    chk("sim_i_ok", 32'(bus.inst_ok), 32'd1);
    chk("sim_i_rdata", bus.inst_rdata, 32'hBBBB_0002);
    tick();
    bus.mem_ready = 1'b0;

    // starvation guard: D D D D I D D D D I
    bus.inst_req = 1'b1;
    bus.data_req = 1'b1;
    for (int t = 0; t < 10; t++) begin
      exp_inst = (t == 4 || t == 9);
      tick();
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'(t);
      #1;
      chk($sformatf("stv_iok%0d", t), 32'(bus.inst_ok), 32'(exp_inst));
      chk($sformatf("stv_dok%0d", t), 32'(bus.data_ok), 32'(!exp_inst));
      tick();
      bus.mem_ready = 1'b0;
    end
    bus.inst_req = 1'b0;
    bus.data_req = 1'b0;

    // timeout: no ready, ok after 8 busy cycles
    tick();
    bus.data_req  = 1'b1;
    bus.data_addr = 32'h0000_3000;
    bus.mem_rdata = 32'hCAFE_F00D;
    for (int k = 1; k <= 8; k++) begin
      tick();
      #1;
      chk($sformatf("to_ok%0d", k), 32'(bus.data_ok), 32'(k == 8));
    end
    chk("to_rdata", bus.data_rdata, 32'd0);
    tick();
    bus.data_req = 1'b0;
    #1;
    chk("to_idle", 32'(bus.mem_req), 32'd0);
    chk("to_err", 32'(bus.timeout_err), 32'd1);

    // following fetch completes normally; error stays sticky
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h0000_4000;
    tick();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0101_0101;
    #1;
    chk("post_ok", 32'(bus.inst_ok), 32'd1);
    chk("post_rdata", bus.inst_rdata, 32'h0101_0101);
    tick();
    bus.mem_ready = 1'b0;
    bus.inst_req  = 1'b0;
    #1;
    chk("post_err", 32'(bus.timeout_err), 32'd1);

    // reset clears the error flag
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("clr_err", 32'(bus.timeout_err), 32'd0);

    // ready in the limit cycle is a normal completion
    bus.data_req  = 1'b1;
    bus.data_addr = 32'h0000_5000;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 8) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h5A5A_5A5A;
      end
      #1;
      chk($sformatf("lim_ok%0d", k), 32'(bus.data_ok), 32'(k == 8));
    end
    chk("lim_rdata", bus.data_rdata, 32'h5A5A_5A5A);
    tick();
    bus.mem_ready = 1'b0;
    bus.data_req  = 1'b0;
    #1;
    chk("lim_err", 32'(bus.timeout_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port synchronous memory between the core's instruction-fetch requester and data-access requester.
- Sits between the core's inst/data SRAM-style interfaces and a unified memory port.
- Grants one access at a time using a fixed-priority scheme with anti-starvation.
- Waits a variable number of cycles for memory completion and drives a stall request back to the pipeline CTRL.

Parameters:
- MAX_DATA_STREAK, 4, maximum consecutive data grants while inst is pending before inst is forced.
- TIMEOUT, 255, cycles to wait for mem_ready before aborting the access (8-bit counter).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- inst_req  in  1  fetch request; held high until inst_ok
- inst_addr  in  32  fetch address
- inst_rdata  out  32  fetch data, valid when inst_ok
- inst_ok  out  1  one-cycle completion pulse for fetch
- data_req  in  1  data request; held high until data_ok
- data_wen  in  4  byte write enables (0 = read)
- data_addr  in  32  data address
- data_wdata  in  32  store data
- data_rdata  out  32  load data, valid when data_ok
- data_ok  out  1  one-cycle completion pulse for data
- mem_req  out  1  memory access active
- mem_wen  out  4  byte write enables to memory
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid with mem_ready
- mem_ready  in  1  memory completion, one-cycle pulse
- stallreq  out  1  pipeline stall request to CTRL
- timeout_err  out  1  sticky error flag, cleared only by rst

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high: rst sampled high on a clk rising edge. After reset:
  - state = IDLE; streak and wait counters = 0.
  - mem_req = 0, mem_wen = 0, mem_addr = 0, mem_wdata = 0.
  - inst_ok = data_ok = 0, timeout_err = 0.
  - rst asserted mid-access abandons the access; mem_req drops the following cycle, and no ok is issued for it.
- FSM states: IDLE, INST_BUSY, DATA_BUSY.
- IDLE (arbitration):
  - Only data_req: go to DATA_BUSY.
  - Only inst_req: go to INST_BUSY.
  - Both requests: go to DATA_BUSY unless streak == MAX_DATA_STREAK, in which case go to INST_BUSY.
  - Neither request: stay in IDLE.
- Capture at grant: requester address, wen and wdata are registered into mem_addr, mem_wen and mem_wdata. For inst grants, mem_wen = 0 and mem_wdata = 0.
- Streak counter: incremented on each data grant made while inst_req is high, saturating at MAX_DATA_STREAK. Cleared on any inst grant, and on a data grant when inst_req is low.
- BUSY states:
  - mem_req = 1 and mem_* held stable.
  - The wait counter increments each cycle.
  - On mem_ready: the granted ok = 1 combinationally in that cycle, granted rdata = mem_rdata (forced to 0 for data writes), then return to IDLE.
- Latency:
  - Request seen in IDLE at cycle N → mem_req high at N+1.
  - Earliest ok is at N+1, when mem_ready arrives at N+1.
  - The next grant is at the cycle after ok; no back-to-back bubble-free issue.
- Requester rules: req is deasserted or changed only in the cycle after its ok. The arbiter never samples req in the same cycle it issues ok, because the FSM is in BUSY during that cycle.
- stallreq = (inst_req & ~inst_ok) | (data_req & ~data_ok), purely combinational.
- Timeout: if the wait counter reaches TIMEOUT without mem_ready:
  - The granted ok pulses with rdata = 0.
  - timeout_err is set (sticky).
  - FSM returns to IDLE; mem_req drops the next cycle.
- Boundary cases:
  - mem_ready while IDLE is ignored.
  - mem_ready in the same cycle the wait counter hits TIMEOUT is treated as normal completion; timeout_err is not set.
  - rdata outputs are undefined unless ok is high; the bench checks them only with ok.

Test Plan:
- Reset: rst high for 2 cycles mid DATA_BUSY → mem_req = 0, data_ok never pulses, timeout_err = 0, state IDLE.
- Single fetch: inst_req with addr 0xBFC00000, mem_ready at the 3rd busy cycle with rdata 0x24080001 → mem_addr = 0xBFC00000, mem_wen = 0, inst_ok one pulse with inst_rdata = 0x24080001, stallreq high until that cycle.
- Store: data_req with wen 4'b0011, addr 0x80000010, wdata 0xDEADBEEF, zero-wait ready → mem_wen = 0011, data_ok pulses at N+1, data_rdata = 0.
- Simultaneous requests: both asserted in the same cycle → data granted first, inst granted in the grant slot immediately after data_ok.
- Starvation: inst_req held while data_req is re-raised after each ok for 6 transactions, MAX_DATA_STREAK = 4 → grant order D,D,D,D,I,D,...; streak cleared after I.
- Timeout: TIMEOUT = 8, mem_ready never asserted → ok pulses 8 busy cycles after grant with rdata = 0, timeout_err stays 1 until rst; a following request completes normally.
